// File: rtl/term_write_ctrl_pkg.sv
// Shared constants for the terminal write path: character codes, commands, states.
package term_write_ctrl_pkg;

  localparam int unsigned CHAR_W  = 6;
  localparam int unsigned COORD_W = 8;

  // Six-bit character set: code = ASCII - 0x20.
  localparam logic [CHAR_W-1:0] CHAR_SPACE = 6'h00;
  localparam logic [CHAR_W-1:0] CHAR_A     = 6'h21;
  localparam logic [CHAR_W-1:0] CHAR_N     = 6'h2E;
  localparam logic [CHAR_W-1:0] CHAR_O     = 6'h2F;
  localparam logic [CHAR_W-1:0] CHAR_T     = 6'h34;

  typedef enum logic [1:0] {
    CMD_PUT = 2'd0,
    CMD_NL  = 2'd1,
    CMD_BS  = 2'd2,
    CMD_CLR = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_CLRLINE = 2'd1,
    ST_IDLE    = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CUR_HOLD = 3'd0,
    CUR_ADV  = 3'd1,
    CUR_NL   = 3'd2,
    CUR_BS   = 3'd3,
    CUR_HOME = 3'd4
  } cur_op_e;

endpackage

// File: rtl/term_write_ctrl_if.sv
// Token input handshake plus single-cell write port toward the display.
interface term_write_ctrl_if;
  import term_write_ctrl_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_cmd;
  logic [CHAR_W-1:0]  in_char;
  logic [COORD_W-1:0] w_h_addr;
  logic [COORD_W-1:0] w_v_addr;
  logic [CHAR_W-1:0]  w_data;
  logic               w_en;

  modport master (
    output in_valid, in_cmd, in_char,
    input  in_ready, w_h_addr, w_v_addr, w_data, w_en
  );

  modport slave (
    input  in_valid, in_cmd, in_char,
    output in_ready, w_h_addr, w_v_addr, w_data, w_en
  );
endinterface

// File: rtl/term_cursor.sv
// Text cursor register with advance / newline / backspace / home operations.
module term_cursor
  import term_write_ctrl_pkg::*;
#(
  parameter int unsigned COLS = 10,
  parameter int unsigned ROWS = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  cur_op_e            op,
  output logic [COORD_W-1:0] cur_h,
  output logic [COORD_W-1:0] cur_v,
  output logic               at_eol_c,
  output logic [COORD_W-1:0] bs_h_c,
  output logic [COORD_W-1:0] bs_v_c,
  output logic               bs_ok_c
);

  localparam logic [COORD_W-1:0] H_MAX = COORD_W'(COLS - 1);
  localparam logic [COORD_W-1:0] V_MAX = COORD_W'(ROWS - 1);

  logic [COORD_W-1:0] v_next_c;

  // Next row with bottom-to-top wrap, and the backspace target cell.
  always_comb begin
    v_next_c = (cur_v == V_MAX) ? '0 : cur_v + 8'd1;
    at_eol_c = (cur_h == H_MAX);
    bs_h_c   = cur_h;
    bs_v_c   = cur_v;
    bs_ok_c  = 1'b0;
    if (cur_h != '0) begin
      bs_h_c  = cur_h - 8'd1;
      bs_ok_c = 1'b1;
    end else if (cur_v != '0) begin
      bs_h_c  = H_MAX;
      bs_v_c  = cur_v - 8'd1;
      bs_ok_c = 1'b1;
    end
  end

  // Cursor register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_h <= '0;
      cur_v <= '0;
    end else begin
      case (op)
        CUR_ADV: begin
          if (at_eol_c) begin
            cur_h <= '0;
            cur_v <= v_next_c;
          end else begin
            cur_h <= cur_h + 8'd1;
          end
        end
        CUR_NL: begin
          cur_h <= '0;
          cur_v <= v_next_c;
        end
        CUR_BS: begin
          cur_h <= bs_h_c;
          cur_v <= bs_v_c;
        end
        CUR_HOME: begin
          cur_h <= '0;
          cur_v <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/term_write_ctrl.sv
// Turns character/command tokens into single-cell display writes and tracks the cursor.
module term_write_ctrl
  import term_write_ctrl_pkg::*;
#(
  parameter int unsigned       COLS  = 10,
  parameter int unsigned       ROWS  = 6,
  parameter logic [CHAR_W-1:0] BLANK = CHAR_SPACE
) (
  input  logic               clk,
  input  logic               rst,
  term_write_ctrl_if.slave   bus,
  output logic [COORD_W-1:0] cur_h,
  output logic [COORD_W-1:0] cur_v,
  output logic               busy
);

  localparam logic [COORD_W-1:0] H_MAX = COORD_W'(COLS - 1);
  localparam logic [COORD_W-1:0] V_MAX = COORD_W'(ROWS - 1);

  state_e             state;
  logic [COORD_W-1:0] sweep_h;
  logic [COORD_W-1:0] sweep_v;
  logic               w_en;
  logic [COORD_W-1:0] w_h_addr;
  logic [COORD_W-1:0] w_v_addr;
  logic [CHAR_W-1:0]  w_data;

  cmd_e               cmd_c;
  cur_op_e            cur_op_c;
  logic               at_eol_c;
  logic [COORD_W-1:0] bs_h_c;
  logic [COORD_W-1:0] bs_v_c;
  logic               bs_ok_c;

  term_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk      (clk),
    .rst      (rst),
    .op       (cur_op_c),
    .cur_h    (cur_h),
    .cur_v    (cur_v),
    .at_eol_c (at_eol_c),
    .bs_h_c   (bs_h_c),
    .bs_v_c   (bs_v_c),
    .bs_ok_c  (bs_ok_c)
  );

  // Cursor operation for this cycle: token effects in IDLE, homing at end of full clear.
  always_comb begin
    cmd_c    = cmd_e'(bus.in_cmd);
    cur_op_c = CUR_HOLD;
    if (state == ST_IDLE && bus.in_valid) begin
      case (cmd_c)
        CMD_PUT: cur_op_c = CUR_ADV;
        CMD_NL:  cur_op_c = CUR_NL;
        CMD_BS:  cur_op_c = CUR_BS;
        default: cur_op_c = CUR_HOLD;
      endcase
    end else if (state == ST_CLEAR && sweep_h == H_MAX && sweep_v == V_MAX) begin
      cur_op_c = CUR_HOME;
    end
  end

  // Sequencer: sweep counters, state and the registered write port (addr/data held when idle).
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_CLEAR;
      sweep_h  <= '0;
      sweep_v  <= '0;
      w_en     <= 1'b0;
      w_h_addr <= '0;
      w_v_addr <= '0;
      w_data   <= '0;
    end else begin
      w_en <= 1'b0;
      case (state)
        ST_CLEAR: begin
          w_en     <= 1'b1;
          w_h_addr <= sweep_h;
          w_v_addr <= sweep_v;
          w_data   <= BLANK;
          if (sweep_h == H_MAX) begin
            sweep_h <= '0;
            if (sweep_v == V_MAX) begin
              sweep_v <= '0;
              state   <= ST_IDLE;
            end else begin
              sweep_v <= sweep_v + 8'd1;
            end
          end else begin
            sweep_h <= sweep_h + 8'd1;
          end
        end
        ST_CLRLINE: begin
          w_en     <= 1'b1;
          w_h_addr <= sweep_h;
          w_v_addr <= cur_v;
          w_data   <= BLANK;
          if (sweep_h == H_MAX) begin
            sweep_h <= '0;
            state   <= ST_IDLE;
          end else begin
            sweep_h <= sweep_h + 8'd1;
          end
        end
        ST_IDLE: begin
          if (bus.in_valid) begin
            case (cmd_c)
              CMD_PUT: begin
                w_en     <= 1'b1;
                w_h_addr <= cur_h;
                w_v_addr <= cur_v;
                w_data   <= bus.in_char;
                if (at_eol_c) begin
                  sweep_h <= '0;
                  state   <= ST_CLRLINE;
                end
              end
              CMD_NL: begin
                sweep_h <= '0;
                state   <= ST_CLRLINE;
              end
              CMD_BS: begin
                if (bs_ok_c) begin
                  w_en     <= 1'b1;
                  w_h_addr <= bs_h_c;
                  w_v_addr <= bs_v_c;
                  w_data   <= BLANK;
                end
              end
              CMD_CLR: begin
                sweep_h <= '0;
                sweep_v <= '0;
                state   <= ST_CLEAR;
              end
            endcase
          end
        end
        default: begin
          sweep_h <= '0;
          sweep_v <= '0;
          state   <= ST_CLEAR;
        end
      endcase
    end
  end

  assign bus.in_ready = (state == ST_IDLE);
  assign busy         = (state != ST_IDLE);
  assign bus.w_en     = w_en;
  assign bus.w_h_addr = w_h_addr;
  assign bus.w_v_addr = w_v_addr;
  assign bus.w_data   = w_data;

endmodule

// File: tb/tb_term_write_ctrl.sv
// Directed self-checking bench for term_write_ctrl on a 10x6 screen.
module tb_term_write_ctrl;
  import term_write_ctrl_pkg::*;

  localparam int unsigned COLS = 10;
  localparam int unsigned ROWS = 6;

  logic        clk;
  logic        rst;
  logic [7:0]  cur_h;
  logic [7:0]  cur_v;
  logic        busy;
  int          n_checks;
  int          n_err;
  logic [5:0]  anton [5];
  logic [5:0]  ch;

  term_write_ctrl_if bus ();

  term_write_ctrl #(.COLS(COLS), .ROWS(ROWS), .BLANK(CHAR_SPACE)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .cur_h (cur_h),
    .cur_v (cur_v),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks one visible write: {w_en, h, v, data}.
  task automatic chk_w(input string tag, input int h, input int v, input logic [5:0] d);
    chk(tag, {9'd0, bus.w_en, bus.w_h_addr, bus.w_v_addr, bus.w_data},
        {9'd0, 1'b1, 8'(h), 8'(v), d});
  endtask

  task automatic chk_cur(input string tag, input int h, input int v);
    chk(tag, {16'd0, cur_h, cur_v}, {16'd0, 8'(h), 8'(v)});
  endtask

  // n consecutive BLANK writes row-major from (0,row0); in_ready high only with the last one if last_rdy.
  task automatic expect_sweep(input string tag, input int n, input int row0, input bit last_rdy);
    for (int i = 0; i < n; i++) begin
      step();
      chk_w(tag, i % COLS, row0 + i / COLS, CHAR_SPACE);
      chk({tag, "_rdy"}, 32'(bus.in_ready), 32'(last_rdy && (i == n - 1)));
    end
  endtask

  // Presents one token for exactly one cycle (DUT must be ready).
  task automatic send(input logic [1:0] cmd, input logic [5:0] c);
    bus.in_valid = 1'b1;
    bus.in_cmd   = cmd;
    bus.in_char  = c;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    anton    = '{CHAR_A, CHAR_N, CHAR_T, CHAR_O, CHAR_N};
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_cmd   = 2'd0;
    bus.in_char  = 6'd0;

    // 1. Reset state, then automatic full-screen clear.
    step();
    step();
    chk("rst_w", {8'd0, bus.w_en, bus.w_h_addr, bus.w_v_addr, bus.w_data}, 32'd0);
    chk("rst_rdy", 32'(bus.in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk_cur("rst_cur", 0, 0);
    rst = 1'b0;
    expect_sweep("clr0", 60, 0, 1'b1);
    step();
    chk("clr0_wen_off", 32'(bus.w_en), 32'd0);
    chk("clr0_busy", 32'(busy), 32'd0);
    chk_cur("clr0_cur", 0, 0);

    // 2. Back-to-back PUTs at full throughput.
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.in_cmd   = CMD_PUT;
      bus.in_char  = anton[k];
      step();
      chk_w("put_anton", k, 0, anton[k]);
      chk("put_anton_rdy", 32'(bus.in_ready), 32'd1);
    end
    bus.in_valid = 1'b0;
    step();
    chk("put_wen_off", 32'(bus.w_en), 32'd0);
    chk("put_data_hold", {bus.w_h_addr, bus.w_v_addr, 10'd0, bus.w_data}, {8'd4, 8'd0, 10'd0, CHAR_N});
    chk_cur("put_cur", 5, 0);

    // 3. Ten PUTs on row 2 wrap into a blanked row 3; a held token is taken afterwards.
    send(CMD_NL, 6'd0);
    chk("nl1_wen", 32'(bus.w_en), 32'd0);
    expect_sweep("nl_row1", 10, 1, 1'b1);
    send(CMD_NL, 6'd0);
    expect_sweep("nl_row2", 10, 2, 1'b1);
    chk_cur("row2_cur", 0, 2);
    for (int k = 0; k < 10; k++) begin
      ch           = 6'(6'h21 + k);
      bus.in_valid = 1'b1;
      bus.in_cmd   = CMD_PUT;
      bus.in_char  = ch;
      step();
      chk_w("wrap_put", k, 2, ch);
      chk("wrap_put_rdy", 32'(bus.in_ready), 32'(k != 9));
    end
    bus.in_char = CHAR_T;
    expect_sweep("wrap_clr", 10, 3, 1'b1);
    chk_cur("wrap_cur", 0, 3);
    step();
    bus.in_valid = 1'b0;
    chk_w("held_put", 0, 3, CHAR_T);
    chk_cur("held_cur", 1, 3);

    // 4. NEWLINE from the bottom row wraps to row 0 and blanks it.
    send(CMD_NL, 6'd0);
    expect_sweep("nl_row4", 10, 4, 1'b1);
    send(CMD_NL, 6'd0);
    expect_sweep("nl_row5", 10, 5, 1'b1);
    send(CMD_PUT, CHAR_A);
    send(CMD_PUT, CHAR_A);
    send(CMD_PUT, CHAR_A);
    chk_cur("pre_nl_cur", 3, 5);
    send(CMD_NL, 6'd0);
    chk("nl_bot_wen", 32'(bus.w_en), 32'd0);
    chk("nl_bot_rdy", 32'(bus.in_ready), 32'd0);
    chk_cur("nl_bot_cur", 0, 0);
    expect_sweep("nl_row0", 10, 0, 1'b1);

    // 5. BACKSPACE within a row, across a row boundary, and at home.
    send(CMD_NL, 6'd0);
    expect_sweep("nl_row1b", 10, 1, 1'b1);
    send(CMD_PUT, CHAR_O);
    send(CMD_PUT, CHAR_O);
    send(CMD_BS, 6'd0);
    chk_w("bs_mid", 1, 1, CHAR_SPACE);
    chk_cur("bs_mid_cur", 1, 1);
    send(CMD_BS, 6'd0);
    chk_w("bs_col0", 0, 1, CHAR_SPACE);
    send(CMD_BS, 6'd0);
    chk_w("bs_up", 9, 0, CHAR_SPACE);
    chk_cur("bs_up_cur", 9, 0);
    for (int k = 8; k >= 0; k--) begin
      send(CMD_BS, 6'd0);
      chk_w("bs_walk", k, 0, CHAR_SPACE);
    end
    send(CMD_BS, 6'd0);
    chk("bs_home_wen", 32'(bus.w_en), 32'd0);
    chk("bs_home_rdy", 32'(bus.in_ready), 32'd1);
    chk_cur("bs_home_cur", 0, 0);

    // 6. CLEAR command homes the cursor; reset mid-clear restarts the sweep.
    send(CMD_PUT, CHAR_A);
    send(CMD_CLR, 6'd0);
    chk("clrcmd_wen", 32'(bus.w_en), 32'd0);
    chk("clrcmd_busy", 32'(busy), 32'd1);
    chk_cur("clrcmd_cur_kept", 1, 0);
    expect_sweep("clrcmd", 60, 0, 1'b1);
    step();
    chk_cur("clrcmd_cur", 0, 0);
    send(CMD_PUT, CHAR_A);
    send(CMD_CLR, 6'd0);
    expect_sweep("clr_part", 25, 0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_wen", 32'(bus.w_en), 32'd0);
    chk("midrst_rdy", 32'(bus.in_ready), 32'd0);
    chk_cur("midrst_cur", 0, 0);
    expect_sweep("clr_restart", 60, 0, 1'b1);
    step();
    chk("final_wen", 32'(bus.w_en), 32'd0);
    chk_cur("final_cur", 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/term_write_ctrl.md
Name: term_write_ctrl

Overview:
Sequences the write port of DisplayTerminal. It accepts a stream of character/command tokens over a valid/ready handshake, maintains the text cursor, and turns each token into one or more single-cell writes (w_h_addr, w_v_addr, w_data, w_en). It also handles auto-wrap, newline, backspace, line blanking and full-screen clear. It sits between any character producer (UART RX, keyboard decoder, test stimulus) and DisplayTerminal.

Parameters:
COLS, 10, text columns (1..255)
ROWS, 6, text rows (1..255)
BLANK, `CHAR_SPACE, 6-bit code written to erased cells

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  token valid
in_ready  out  1  token accepted when in_valid & in_ready
in_cmd  in  2  0=PUT, 1=NEWLINE, 2=BACKSPACE, 3=CLEAR
in_char  in  6  character code (PUT only)
w_h_addr  out  8  cell column to DisplayTerminal
w_v_addr  out  8  cell row to DisplayTerminal
w_data  out  6  cell data
w_en  out  1  cell write strobe
cur_h  out  8  current cursor column
cur_v  out  8  current cursor row
busy  out  1  high in CLEAR or CLRLINE

Behaviour:
- All outputs are registered. Every write appears on w_* exactly one cycle after the cycle that decides it.
- States: CLEAR, CLRLINE, IDLE. in_ready = (state==IDLE). busy = ~in_ready.
- Reset: state=CLEAR, sweep counters=(0,0), cur=(0,0), w_en=0, w_h_addr=0, w_v_addr=0, w_data=0. The screen is blanked automatically after reset.
- CLEAR: writes BLANK to every cell in row-major order, one cell per cycle: (0,0),(1,0)..(COLS-1,0),(0,1)..(COLS-1,ROWS-1). That is COLS*ROWS consecutive w_en pulses. After the last cell: cur=(0,0), go to IDLE.
- CLRLINE: writes BLANK to columns 0..COLS-1 of row cur_v, one per cycle, then goes to IDLE. Cursor is unchanged.
- IDLE, PUT accepted:
  - Write in_char at (cur_h, cur_v).
  - If cur_h<COLS-1: cur_h+1.
  - Otherwise wrap: cur_h=0, cur_v=(cur_v==ROWS-1)?0:cur_v+1, then enter CLRLINE on the new row.
- IDLE, NEWLINE accepted: no write. cur_h=0, cur_v advances with the same wrap rule, then enter CLRLINE.
- IDLE, BACKSPACE accepted:
  - If cur_h>0: cur_h-1 and write BLANK at the new position.
  - Else if cur_v>0: cur=(COLS-1, cur_v-1) and write BLANK there.
  - At (0,0): no write, no move.
- IDLE, CLEAR accepted: enter CLEAR with sweep reset to (0,0).
- No scrolling. The bottom row wraps to row 0, and the row being entered is always blanked first.
- Throughput in IDLE is one PUT per cycle (in_ready stays high).
- in_ready deasserts in the cycle after a token that enters CLEAR/CLRLINE is accepted. Tokens presented while in_ready=0 are held by the producer, not dropped.
- w_en is low in any cycle with no write. w_data/addr are don't-care when w_en=0, but must hold their last values (no toggling).
- rst asserted mid-CLEAR/CLRLINE/IDLE: restarts the full CLEAR from (0,0) on the next cycle. Any in-flight token is discarded.
- Counters compare against COLS-1/ROWS-1 and use 8-bit widths. COLS=1 or ROWS=1 must wrap correctly (column/row stays 0).

Decomposition:
- Shared constants header (existing const file): CHAR_* codes incl. CHAR_SPACE, plus CMD_PUT/CMD_NL/CMD_BS/CMD_CLR and state encodings.
- One sub-module is natural: term_cursor (cursor register with advance/newline/backspace operations and wrap logic), instantiated once.
- The sweep counter stays in term_write_ctrl.

Test Plan:
1. Reset, hold in_valid=0: expect 60 consecutive w_en pulses (10x6), row-major, w_data=BLANK, first at (0,0), last at (9,5). in_ready rises the cycle after, cur=(0,0).
2. After clear, PUT 'A','N','T','O','N' back-to-back: writes at (0..4,0) one per cycle, data in order, in_ready never drops, cur=(5,0).
3. 10 PUTs starting at (0,2): last write at (9,2), then 10 BLANK writes on row 3, in_ready low exactly 10 cycles, cur=(0,3).
4. Cursor at (3,5), NEWLINE: no char write, CLRLINE blanks row 0 (10 writes), cur=(0,0).
5. BACKSPACE at (2,1) gives a BLANK write at (1,1), cur=(1,1). At (0,1) it gives a BLANK write at (9,0). At (0,0) there is no w_en and cur stays (0,0).
6. Assert rst for 1 cycle midway through a CLEAR command (after 25 writes): sweep restarts at (0,0), full 60 writes, cur=(0,0).
